// File: rtl/pim_result_buffer.sv
// Two-entry ping-pong buffer for PIM macro results.
// Captures a packed result vector and serves it as bus words.
module pim_result_buffer #(
   parameter  int RES_W   = 16,
   parameter  int NUM_RES = 8,
   parameter  int DATA_W  = 32,
   localparam int VEC_W   = NUM_RES * RES_W,
   localparam int WORDS   = VEC_W / DATA_W,
   localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_result_in_en,
   input  logic [VEC_W-1:0]  i_result_data,
   input  logic              i_result_out_en,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rdata_valid,
   output logic [IDX_W-1:0]  o_word_idx,
   output logic [1:0]        o_level,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_overflow
);

   if ((DATA_W % RES_W) != 0 || (VEC_W % DATA_W) != 0) begin : g_bad_cfg
      $error("pim_result_buffer: DATA_W must divide into results evenly");
   end

   localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

   logic [VEC_W-1:0]  bank [2];
   logic              wr_bank;
   logic              rd_bank;
   logic [VEC_W-1:0]  rd_vec;
   logic [DATA_W-1:0] words [WORDS];
   logic [DATA_W-1:0] rd_word;
   logic              rd_fire;
   logic              rd_last;
   logic              cap_ok;

   assign rd_vec = bank[rd_bank];

   for (genvar w = 0; w < WORDS; w++) begin : g_word
      assign words[w] = rd_vec[w*DATA_W +: DATA_W];
   end

   assign rd_word = words[o_word_idx];
   assign rd_fire = i_result_out_en && (o_level != 2'd0);
   assign rd_last = rd_fire && (o_word_idx == LAST);
   // A completing read frees its bank this cycle, so a full buffer
   // can still accept a capture alongside it.
   assign cap_ok  = i_result_in_en && (!o_level[1] || rd_last);

   assign o_empty = (o_level == 2'd0);
   assign o_full  = (o_level == 2'd2);

   always_ff @(posedge i_clk) begin
      if (cap_ok && !i_clear) begin
         bank[wr_bank] <= i_result_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         o_word_idx    <= '0;
         o_level       <= 2'd0;
         o_rdata       <= '0;
         o_rdata_valid <= 1'b0;
         o_overflow    <= 1'b0;
      end else if (i_clear) begin
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         o_word_idx    <= '0;
         o_level       <= 2'd0;
         o_rdata_valid <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         o_rdata_valid <= rd_fire;
         if (i_result_out_en) begin
            o_rdata <= rd_fire ? rd_word : '0;
         end
         if (rd_fire) begin
            if (rd_last) begin
               o_word_idx <= '0;
               rd_bank    <= ~rd_bank;
            end else begin
               o_word_idx <= o_word_idx + IDX_W'(1);
            end
         end
         if (cap_ok) begin
            wr_bank <= ~wr_bank;
         end else if (i_result_in_en) begin
            o_overflow <= 1'b1;
         end
         unique case (1'b1)
            (cap_ok && !rd_last): o_level <= o_level + 2'd1;
            (!cap_ok && rd_last): o_level <= o_level - 2'd1;
            default:              o_level <= o_level;
         endcase
      end
   end

endmodule
